rtob_sched_ctrl: RTL
====================

# rtob_sched_ctrl

Front-end controller for one RTOB core (timestamped output buffer). It shares the core's single write port among NUM_SRC requesters using round-robin arbitration and sequences the core's `auto_start` and `flush` controls through a run/halt/flush state machine. It also checks that written timestamps never decrease and latches error status. It sits between the command/DMA sources and the RTOB core's `write`/`fifo_din` inputs.

## Interface
Parameters:
- NUM_SRC, 4, number of requesters (2..8)
- FLUSH_CYCLES, 4, cycles `rtob_flush` is held high per flush (1..255)
- STOP_ON_ERROR, 1, 1 = any error moves the FSM to HALT; 0 = errors only latch status

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- src_valid  in  NUM_SRC  per-requester word valid
- src_data  in  NUM_SRC*128  per-requester word; bits [127:64] are the timestamp, [63:0] the payload; source i occupies [128*i+127:128*i]
- src_ready  out  NUM_SRC  one-hot grant; a word transfers when valid&ready
- cmd_start / cmd_stop / cmd_flush  in  1 each  single-cycle command pulses
- rtob_full  in  1  core prog_full
- rtob_timestamp_error / rtob_overflow_error  in  1 each  core error pulses
- rtob_write  out  1  core write strobe
- rtob_din  out  128  core write data
- rtob_auto_start  out  1  core auto_start
- rtob_flush  out  1  core flush
- state  out  2  IDLE=0, RUN=1, HALT=2, FLUSH=3
- err_flags  out  3  sticky flags {ts_order, overflow, timestamp}
- err_src  out  3  index of the source whose word raised ts_order
- write_count  out  32  words written since the last flush or reset

## Operation
- A word is accepted only when state is IDLE or RUN, `rtob_full`=0, and no `cmd_flush` is present in the same cycle.
- Arbitration:
  - Combinational round-robin. The search starts at (last_grant+1) mod NUM_SRC.
  - At most one ready bit per cycle, and only toward a source with valid=1.
  - last_grant updates only on a transfer.
- Accepted word: registered into `rtob_din`, with `rtob_write`=1 on the next cycle. `write_count` increments on that same cycle and wraps at 2^32.
- FSM transitions. Priority: cmd_flush > error > cmd_stop > cmd_start.
  - IDLE: `auto_start`=0; writes allowed. cmd_start → RUN; cmd_flush → FLUSH.
  - RUN: `auto_start`=1; writes allowed. Error with STOP_ON_ERROR=1 → HALT; cmd_stop → IDLE; cmd_flush → FLUSH.
  - HALT: `auto_start`=0; writes blocked. Only cmd_flush → FLUSH. cmd_start and cmd_stop are ignored.
  - FLUSH: `rtob_flush`=1 for exactly FLUSH_CYCLES cycles, then IDLE. The flush also:
    - clears `err_flags`, `err_src`, `write_count` and the last-timestamp register;
    - sets last_grant to NUM_SRC-1, so source 0 has priority next.
- Error sources:
  - `rtob_timestamp_error` / `rtob_overflow_error` high in any state except FLUSH → set the matching sticky flag.
  - The ts_order check also counts as an error for the FSM (HALT transition).
- cmd_flush during FLUSH restarts the FLUSH_CYCLES count.

## Timing
- Reset values: src_ready=0, rtob_write=0, rtob_din=0, rtob_auto_start=0, rtob_flush=0, state=IDLE, err_flags=0, err_src=0, write_count=0, last_grant=NUM_SRC-1.
- Handshake → rtob_write: latency 1 cycle. Full throughput is one word per cycle.
- `rtob_full` is sampled combinationally. The core's prog_full margin covers the one word in flight.
- Command, error input, or flag → state change: registered 1 cycle later.
- `rtob_auto_start` and `rtob_flush` are decoded from registered state, so they are glitch-free.
- On entering HALT or FLUSH, the word registered in the preceding cycle is still written.
- reset_n low mid-operation: all outputs go immediately to their reset values; the in-flight word is discarded.

## Configuration
- RTOB_SCHED_TS_CHECK_EN defined:
  - Each accepted word's timestamp is compared with the last written timestamp.
  - If it is smaller, the word is consumed (ready=1) but not written. err_flags[2] is set, err_src records the source index, and the FSM treats it as an error.
  - Equal timestamps are legal.
  - The first word after a flush or reset is always legal.
- Undefined: no comparator is built. Every accepted word is written and err_flags[2] and err_src are tied to 0.

## Test plan
- Setup: after reset, all sources valid with ts = 0x10 + i. Cmd_start.
  → Grants issued in order 0, 1, 2, 3, 0.
  → rtob_write follows 1 cycle after each grant; write_count=5 after 5 words.
- Backpressure: rtob_full=1 for 3 cycles with source 2 valid → src_ready=0 throughout; the grant resumes the cycle full drops and no word is lost.
- Order check (RTOB_SCHED_TS_CHECK_EN): source 1 writes ts=0x100, then source 3 offers ts=0xFF in RUN.
  → Word dropped.
  → err_flags=3'b100, err_src=3.
  → state=HALT next cycle; auto_start=0.
- Core error: rtob_overflow_error pulse in RUN → err_flags[1]=1, then HALT. cmd_start is ignored. cmd_flush then gives rtob_flush high for 4 cycles, followed by IDLE with flags and write_count at 0.
- Command collision: cmd_stop and cmd_flush in the same RUN cycle → FLUSH wins. A second cmd_flush at flush cycle 2 extends rtob_flush to 6 cycles total.
- Asynchronous reset: assert reset_n low mid-burst while rtob_write=1 → outputs go to reset values without waiting for a clock edge; the first grant after release goes to source 0.

Source files
------------

// File: rtl/rtob_sched_ctrl_if.sv
// Requester-side bundle of the RTOB scheduler: per-source word valid/data and the
// one-hot ready returned by the round-robin arbiter.
interface rtob_sched_ctrl_if #(
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC-1:0]     src_valid;
    logic [NUM_SRC*128-1:0] src_data;
    logic [NUM_SRC-1:0]     src_ready;

    modport master (
        output src_valid,
        output src_data,
        input  src_ready
    );

    modport slave (
        input  src_valid,
        input  src_data,
        output src_ready
    );
endinterface

// File: rtl/rtob_sched_ctrl.sv
// RTOB front-end: round-robin write arbitration, run/halt/flush sequencing and error latch.
// Optional timestamp-order checker enabled by defining RTOB_SCHED_TS_CHECK_EN.
module rtob_sched_ctrl #(
    parameter int NUM_SRC       = 4,
    parameter int FLUSH_CYCLES  = 4,
    parameter bit STOP_ON_ERROR = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    rtob_sched_ctrl_if.slave    src,
    input  logic                cmd_start,
    input  logic                cmd_stop,
    input  logic                cmd_flush,
    input  logic                rtob_full,
    input  logic                rtob_timestamp_error,
    input  logic                rtob_overflow_error,
    output logic                rtob_write,
    output logic [127:0]        rtob_din,
    output logic                rtob_auto_start,
    output logic                rtob_flush,
    output logic [1:0]          state,
    output logic [2:0]          err_flags,
    output logic [2:0]          err_src,
    output logic [31:0]         write_count
);

    localparam int IW = $clog2(NUM_SRC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_FLUSH = 2'd3
    } state_e;

    state_e        state_q;
    logic          auto_q;
    logic          flush_q;
    logic [7:0]    fcnt_q;
    logic [IW-1:0] last_q;
    logic          write_q;
    logic [127:0]  din_q;
    logic [31:0]   count_q;
    logic [2:0]    flags_q;
    logic [2:0]    esrc_q;

    logic [127:0]  words [NUM_SRC];
    logic [IW-1:0] cand;
    logic [IW-1:0] win_idx;
    logic          win_found;
    logic [127:0]  win_word;
    logic          can_accept;
    logic          xfer;
    logic          ts_bad;
    logic          core_err;
    logic          any_err;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign words[g] = src.src_data[128*g +: 128];
    end

    // Round-robin search starting one past the last granted source
    always_comb begin
        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = IW'((int'(last_q) + k) % NUM_SRC);
            if (!win_found && src.src_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_word   = words[win_idx];
    assign can_accept = reset_n && !rtob_full && !cmd_flush &&
                        (state_q == S_IDLE || state_q == S_RUN);
    assign xfer       = can_accept && win_found;

    assign src.src_ready = xfer ? (NUM_SRC'(1) << win_idx) : '0;

`ifdef RTOB_SCHED_TS_CHECK_EN
    logic [63:0] last_ts_q;
    logic        ts_seen_q;

    assign ts_bad = xfer && ts_seen_q && (win_word[127:64] < last_ts_q);

    // Track the timestamp of the most recent written word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_ts_q <= '0;
            ts_seen_q <= 1'b0;
        end else if (state_q == S_FLUSH) begin
            last_ts_q <= '0;
            ts_seen_q <= 1'b0;
        end else if (xfer && !ts_bad) begin
            last_ts_q <= win_word[127:64];
            ts_seen_q <= 1'b1;
        end
    end
`else
    assign ts_bad = 1'b0;
`endif

    assign core_err = (rtob_timestamp_error || rtob_overflow_error) &&
                      (state_q != S_FLUSH);
    assign any_err  = core_err || ts_bad;

    // Write path: register the granted word and count it as it is written
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_q <= 1'b0;
            din_q   <= '0;
            count_q <= '0;
            last_q  <= IW'(NUM_SRC - 1);
        end else begin
            write_q <= xfer && !ts_bad;
            if (xfer && !ts_bad) begin
                din_q <= win_word;
            end
            if (state_q == S_FLUSH) begin
                count_q <= '0;
                last_q  <= IW'(NUM_SRC - 1);
            end else begin
                if (xfer) begin
                    last_q <= win_idx;
                end
                if (xfer && !ts_bad) begin
                    count_q <= count_q + 32'd1;
                end
            end
        end
    end

    // Sticky error status, wiped while flushing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= '0;
            esrc_q  <= '0;
        end else if (state_q == S_FLUSH) begin
            flags_q <= '0;
            esrc_q  <= '0;
        end else begin
            if (rtob_timestamp_error) begin
                flags_q[0] <= 1'b1;
            end
            if (rtob_overflow_error) begin
                flags_q[1] <= 1'b1;
            end
            if (ts_bad) begin
                flags_q[2] <= 1'b1;
                esrc_q     <= 3'(win_idx);
            end
        end
    end

    // Run/halt/flush sequencer with registered core controls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            auto_q  <= 1'b0;
            flush_q <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_flush) begin
                        state_q <= S_FLUSH;
                        flush_q <= 1'b1;
                        fcnt_q  <= 8'(FLUSH_CYCLES - 1);
                    end else if (!(STOP_ON_ERROR && any_err) && cmd_start) begin
                        state_q <= S_RUN;
                        auto_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (cmd_flush) begin
                        state_q <= S_FLUSH;
                        auto_q  <= 1'b0;
                        flush_q <= 1'b1;
                        fcnt_q  <= 8'(FLUSH_CYCLES - 1);
                    end else if (STOP_ON_ERROR && any_err) begin
                        state_q <= S_HALT;
                        auto_q  <= 1'b0;
                    end else if (cmd_stop) begin
                        state_q <= S_IDLE;
                        auto_q  <= 1'b0;
                    end
                end
                S_HALT: begin
                    if (cmd_flush) begin
                        state_q <= S_FLUSH;
                        flush_q <= 1'b1;
                        fcnt_q  <= 8'(FLUSH_CYCLES - 1);
                    end
                end
                S_FLUSH: begin
                    if (cmd_flush) begin
                        fcnt_q <= 8'(FLUSH_CYCLES - 1);
                    end else if (fcnt_q == 8'd0) begin
                        state_q <= S_IDLE;
                        flush_q <= 1'b0;
                    end else begin
                        fcnt_q <= fcnt_q - 8'd1;
                    end
                end
            endcase
        end
    end

    assign rtob_write      = write_q;
    assign rtob_din        = din_q;
    assign rtob_auto_start = auto_q;
    assign rtob_flush      = flush_q;
    assign state           = state_q;
    assign err_flags       = flags_q;
    assign err_src         = esrc_q;
    assign write_count     = count_q;

endmodule
